// File: rtl/ex_muldiv_unit_if.sv
// Handshake and operand bundle between the E stage and the iterative RV32M multiply/divide unit.
// master is the pipeline side, slave is the unit.
interface ex_muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             iStartE;
   logic [2:0]       iFunct3E;
   logic [WIDTH-1:0] iRD1E;
   logic [WIDTH-1:0] iRD2E;
   logic [4:0]       iRdE;
   logic             iFlushE;
   logic             oBusyE;
   logic             oDoneE;
   logic [WIDTH-1:0] oResultE;
   logic [4:0]       oRdE;

   modport master (
      output iStartE, iFunct3E, iRD1E, iRD2E, iRdE, iFlushE,
      input  oBusyE, oDoneE, oResultE, oRdE
   );

   modport slave (
      input  iStartE, iFunct3E, iRD1E, iRD2E, iRdE, iFlushE,
      output oBusyE, oDoneE, oResultE, oRdE
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the E stage: shift-add multiply, restoring divide.
// Define MULDIV_FAST_MUL_EN to resolve the four multiply ops in one cycle with a 33x33 signed multiplier.
module ex_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic               iClk,
   input  logic               iRst,
   ex_muldiv_unit_if.slave    bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_reg, state_next;
   logic [2:0]       funct3_reg, funct3_next;
   logic [4:0]       rd_reg, rd_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH:0]   acc_reg, acc_next;
   logic [WIDTH-1:0] lo_reg, lo_next;
   logic [WIDTH-1:0] opb_reg, opb_next;
   logic             neg_reg, neg_next;
   logic [WIDTH-1:0] result_reg, result_next;
   logic [4:0]       rdo_reg, rdo_next;

   // Operand decode for a start in IDLE.
   logic [2:0]       f3;
   logic             a_signed, b_signed, a_neg, b_neg, start_neg;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             div_zero, div_ovf, div_special;
   logic [WIDTH-1:0] special_res;
   logic             direct_en;
   logic [WIDTH-1:0] direct_res;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   assign f3        = bus.iFunct3E;
   assign a_signed  = f3[2] ? ~f3[0] : ~(f3[1] & f3[0]);
   assign b_signed  = f3[2] ? ~f3[0] : ~f3[1];
   assign a_neg     = a_signed & bus.iRD1E[WIDTH-1];
   assign b_neg     = b_signed & bus.iRD2E[WIDTH-1];
   assign mag_a     = a_neg ? -bus.iRD1E : bus.iRD1E;
   assign mag_b     = b_neg ? -bus.iRD2E : bus.iRD2E;
   // A remainder takes the dividend's sign; every other op takes the product/quotient sign.
   assign start_neg = (f3 == 3'b110) ? a_neg : (a_neg ^ b_neg);

   assign div_zero    = f3[2] && (bus.iRD2E == '0);
   assign div_ovf     = f3[2] && !f3[0] && (bus.iRD1E == MIN_VAL) && (bus.iRD2E == '1);
   assign div_special = div_zero | div_ovf;

   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = f3[1] ? bus.iRD1E : '1;
      else if (div_ovf)
         special_res = f3[1] ? '0 : MIN_VAL;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic signed [WIDTH:0]       fast_a, fast_b;
   logic signed [2*WIDTH+1:0]   fast_prod_unused;
   logic [WIDTH-1:0]            fast_res;

   assign fast_a           = {a_signed & bus.iRD1E[WIDTH-1], bus.iRD1E};
   assign fast_b           = {b_signed & bus.iRD2E[WIDTH-1], bus.iRD2E};
   assign fast_prod_unused = fast_a * fast_b;
   assign fast_res         = (f3[1:0] == 2'b00) ? fast_prod_unused[WIDTH-1:0]
                                                : fast_prod_unused[2*WIDTH-1:WIDTH];
   assign direct_en        = div_special | ~f3[2];
   assign direct_res       = f3[2] ? special_res : fast_res;
`else
   assign direct_en        = div_special;
   assign direct_res       = special_res;
`endif

   // One iteration of the shared datapath: acc holds the product high half or the partial remainder.
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   mul_sum, mul_acc, div_shift, div_diff, div_acc, step_acc;
   logic [WIDTH-1:0] mul_lo, div_lo, step_lo;
   logic             div_ge;

   assign addend    = lo_reg[0] ? opb_reg : {WIDTH{1'b0}};
   assign mul_sum   = acc_reg + {1'b0, addend};
   assign mul_acc   = {1'b0, mul_sum[WIDTH:1]};
   assign mul_lo    = {mul_sum[0], lo_reg[WIDTH-1:1]};

   assign div_shift = {acc_reg[WIDTH-1:0], lo_reg[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opb_reg};
   assign div_diff  = div_shift - {1'b0, opb_reg};
   assign div_acc   = div_ge ? div_diff : div_shift;
   assign div_lo    = {lo_reg[WIDTH-2:0], div_ge};

   assign step_acc  = funct3_reg[2] ? div_acc : mul_acc;
   assign step_lo   = funct3_reg[2] ? div_lo  : mul_lo;

   // Sign fixup applied to the result of the final iteration.
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quot_s, rem_s, fin_res;

   assign prod   = {step_acc[WIDTH-1:0], step_lo};
   assign prod_s = neg_reg ? -prod : prod;
   assign quot_s = neg_reg ? -step_lo : step_lo;
   assign rem_s  = neg_reg ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];

   always_comb begin
      case (funct3_reg)
         3'b000:                 fin_res = prod_s[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fin_res = prod_s[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         fin_res = quot_s;
         default:                fin_res = rem_s;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      funct3_next = funct3_reg;
      rd_next     = rd_reg;
      cnt_next    = cnt_reg;
      acc_next    = acc_reg;
      lo_next     = lo_reg;
      opb_next    = opb_reg;
      neg_next    = neg_reg;
      result_next = result_reg;
      rdo_next    = rdo_reg;
      if (bus.iFlushE) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.iStartE) begin
                  funct3_next = f3;
                  rd_next     = bus.iRdE;
                  neg_next    = start_neg;
                  acc_next    = '0;
                  lo_next     = mag_a;
                  opb_next    = mag_b;
                  cnt_next    = CW'(WIDTH);
                  if (direct_en) begin
                     result_next = direct_res;
                     rdo_next    = bus.iRdE;
                     state_next  = DONE;
                  end else begin
                     state_next  = CALC;
                  end
               end
            end
            CALC: begin
               acc_next = step_acc;
               lo_next  = step_lo;
               cnt_next = cnt_reg - CW'(1);
               if (cnt_reg == CW'(1)) begin
                  result_next = fin_res;
                  rdo_next    = rd_reg;
                  state_next  = DONE;
               end
            end
            // The finished instruction still sits in E here, so a start is not a new op.
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_reg  <= IDLE;
         funct3_reg <= '0;
         rd_reg     <= '0;
         cnt_reg    <= '0;
         acc_reg    <= '0;
         lo_reg     <= '0;
         opb_reg    <= '0;
         neg_reg    <= 1'b0;
         result_reg <= '0;
         rdo_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         funct3_reg <= funct3_next;
         rd_reg     <= rd_next;
         cnt_reg    <= cnt_next;
         acc_reg    <= acc_next;
         lo_reg     <= lo_next;
         opb_reg    <= opb_next;
         neg_reg    <= neg_next;
         result_reg <= result_next;
         rdo_reg    <= rdo_next;
      end
   end

   assign bus.oBusyE   = (state_reg == CALC) ||
                         ((state_reg == IDLE) && bus.iStartE && !bus.iFlushE);
   assign bus.oDoneE   = (state_reg == DONE) && !bus.iFlushE;
   assign bus.oResultE = result_reg;
   assign bus.oRdE     = rdo_reg;
endmodule
